// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Optional macro LEADING_ZERO_BLANK_EN suppresses enables of leading-zero digits.
module digit_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_COUNT    = 50000,
  parameter int DIV_WIDTH    = 16,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    value_load,
  input  logic                    blank_in,
  output logic                    load_ack,
  output logic [3:0]              digit_out,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_start
);

  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {ST_BLANK, ST_SCAN} state_t;

  state_t                       r_state, w_state_nxt;
  logic [DIV_WIDTH-1:0]         r_div;
  logic [SW-1:0]                r_slot;
  logic [NUM_DIGITS-1:0][3:0]   r_active, r_pending;
  logic                         r_pend_vld, r_ack_pend;
  logic                         w_div_wrap, w_frame_wrap, w_commit;
  logic [NUM_DIGITS-1:0]        w_sup, w_en_n_nxt;

  assign w_div_wrap   = (r_div == DIV_WIDTH'(DIV_COUNT - 1));
  assign w_frame_wrap = w_div_wrap && (r_slot == SW'(NUM_DIGITS - 1));
  assign w_commit     = w_frame_wrap && (r_pend_vld || value_load);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div  <= '0;
      r_slot <= '0;
    end else if (w_div_wrap) begin
      r_div  <= '0;
      r_slot <= w_frame_wrap ? '0 : r_slot + 1'b1;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

  // A load coinciding with the commit bypasses pending so the newest value wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active   <= '0;
      r_pending  <= '0;
      r_pend_vld <= 1'b0;
      r_ack_pend <= 1'b0;
    end else begin
      r_ack_pend <= w_commit;
      if (w_commit) begin
        r_active   <= value_load ? value_in : r_pending;
        r_pend_vld <= 1'b0;
      end else if (value_load) begin
        r_pending  <= value_in;
        r_pend_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_BLANK;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_BLANK && w_commit) w_state_nxt = ST_SCAN;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic w_hi_zero;
  always_comb begin
    w_sup     = '0;
    w_hi_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_hi_zero = w_hi_zero & (r_active[k] == 4'h0);
      w_sup[k]  = w_hi_zero;
    end
  end
`else
  assign w_sup = '0;
`endif

  always_comb begin
    w_en_n_nxt = '1;
    if (r_state == ST_SCAN && !blank_in && r_div >= DIV_WIDTH'(GUARD_CYCLES) && !w_sup[r_slot])
      w_en_n_nxt[r_slot] = 1'b0;
  end

  // Outputs are registered from the current slot state, so they trail the prescaler by one clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_out   <= 4'h0;
      digit_en_n  <= '1;
      frame_start <= 1'b0;
      load_ack    <= 1'b0;
    end else begin
      digit_out   <= r_active[r_slot];
      digit_en_n  <= w_en_n_nxt;
      frame_start <= (r_div == '0) && (r_slot == '0);
      load_ack    <= r_ack_pend;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with NUM_DIGITS=4, DIV_COUNT=8, GUARD_CYCLES=2.
module tb_digit_scan_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] value_in;
  logic        value_load, blank_in;
  logic        load_ack, frame_start;
  logic [3:0]  digit_out, digit_en_n;

  int n_chk  = 0;
  int n_fail = 0;
  int t      = 0;

  always #5 clk = ~clk;

  digit_scan_ctrl #(.NUM_DIGITS(4), .DIV_COUNT(8), .DIV_WIDTH(4), .GUARD_CYCLES(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .value_in(value_in), .value_load(value_load),
    .blank_in(blank_in), .load_ack(load_ack), .digit_out(digit_out),
    .digit_en_n(digit_en_n), .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Output phase after tick t is (t-1) mod 32 within the frame.
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 33 && ((t - 1) % 32) != ph; i++) tick();
  endtask

  task automatic load(input logic [15:0] v);
    value_in   = v;
    value_load = 1'b1;
    tick();
    value_load = 1'b0;
  endtask

  task automatic run_to_frame();
    for (int i = 0; i < 40 && (t % 32) != 0; i++) begin
      tick();
      chk("idle_ack", load_ack, 0);
    end
    tick();
  endtask

  function automatic bit suppressed(input logic [15:0] v, input int slot);
`ifdef LEADING_ZERO_BLANK_EN
    logic [15:0] hi;
    hi = v >> (4 * slot);
    return (slot > 0) && (hi == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  // Checks one whole frame; entry is at output phase 0, exit at phase 31.
  task automatic check_frame(input logic [15:0] v, input bit ack, input bit lit);
    logic [15:0] sh;
    logic [3:0]  exp_en;
    int          slot;
    for (int p = 0; p < 32; p++) begin
      slot   = p / 8;
      sh     = v >> (4 * slot);
      exp_en = 4'hF;
      if (lit && (p % 8) >= 2 && !suppressed(v, slot)) exp_en[slot] = 1'b0;
      chk("digit_out", digit_out, sh[3:0]);
      chk("digit_en_n", digit_en_n, exp_en);
      chk("frame_start", frame_start, (p == 0));
      chk("load_ack", load_ack, (ack && p == 0));
      if (p < 31) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; value_in = '0; value_load = 1'b0; blank_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digit", digit_out, 0);
    chk("rst_en", digit_en_n, 4'hF);
    chk("rst_ack", load_ack, 0);
    chk("rst_fs", frame_start, 0);
    reset_n = 1'b1;
    t = 0;

    // Idle after reset: blank display, periodic frame_start, no ack.
    for (int i = 0; i < 80; i++) begin
      tick();
      chk("idle_fs", frame_start, (((t - 1) % 32) == 0));
      chk("idle_en", digit_en_n, 4'hF);
      chk("idle_ack0", load_ack, 0);
    end

    // First load mid-slot 1.
    wait_phase(10);
    load(16'h1A3F);
    run_to_frame();
    check_frame(16'h1A3F, 1'b1, 1'b1);

    // Two loads in one frame: last one wins, single ack.
    wait_phase(3);
    load(16'h1111);
    wait_phase(20);
    load(16'h2222);
    run_to_frame();
    check_frame(16'h2222, 1'b1, 1'b1);
    tick();
    check_frame(16'h2222, 1'b0, 1'b1);

    // Load on the commit cycle overrides the pending value.
    wait_phase(10);
    load(16'h9999);
    wait_phase(30);
    load(16'h5555);
    run_to_frame();
    check_frame(16'h5555, 1'b1, 1'b1);
    tick();
    check_frame(16'h5555, 1'b0, 1'b1);

    // blank_in forces enables off for a frame; digits keep scanning.
    blank_in = 1'b1;
    tick();
    check_frame(16'h5555, 1'b0, 1'b0);
    blank_in = 1'b0;
    tick();
    check_frame(16'h5555, 1'b0, 1'b1);

    // Asynchronous reset mid-slot 2 with a load pending.
    wait_phase(5);
    load(16'h7777);
    wait_phase(18);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_digit", digit_out, 0);
    chk("arst_en", digit_en_n, 4'hF);
    chk("arst_ack", load_ack, 0);
    chk("arst_fs", frame_start, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    t = 0;
    tick();
    check_frame(16'h0000, 1'b0, 1'b0);
    tick();
    check_frame(16'h0000, 1'b0, 1'b0);

    // Leading-zero values; suppression applies only with the macro defined.
    wait_phase(4);
    load(16'h0000);
    run_to_frame();
    check_frame(16'h0000, 1'b1, 1'b1);
    wait_phase(4);
    load(16'h0070);
    run_to_frame();
    check_frame(16'h0070, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
